// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: owner ids, FSM states, transfer size codes.
package sram_port_arbiter_pkg;

    typedef enum logic {
        OwnerInst = 1'b0,
        OwnerData = 1'b1
    } owner_e;

    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } arb_state_e;

    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

endpackage

// File: rtl/sram_port_arbiter_owner_fifo.sv
// In-order FIFO of 1-bit owner ids for accepted-but-unanswered bus requests.
// Push and pop in the same cycle are both honoured, including when full.
module sram_port_arbiter_owner_fifo
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  owner_e push_owner,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output owner_e head
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Depth-1:0] mem_q, mem_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    assign full  = (cnt_q == CntW'(Depth));
    assign empty = (cnt_q == '0);
    assign head  = owner_e'(mem_q[rd_ptr_q]);

    // Next-state for storage, pointers (wrap naturally, Depth is a power of 2) and count
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_owner;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like bridge port between the IF inst port and the EXE data port.
// Grant is locked until bus_addr_ok; responses are routed back in order via an owner FIFO.
// Build option ARB_RR_EN: round-robin arbitration instead of fixed data-over-inst priority.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned OUTS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,

    output logic        arb_err
);

    arb_state_e state_q, state_d;
    owner_e     grant_q, grant_d;
    owner_e     win;
    owner_e     grant;
    owner_e     head;
    logic       fifo_full, fifo_empty;
    logic       accept, pop, can_issue;
    logic       arb_err_q, arb_err_d;

`ifdef ARB_RR_EN
    owner_e rr_q, rr_d;

    // Round-robin pointer flips after every accepted request
    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            rr_d = owner_e'(~rr_q);
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= OwnerData;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Pick a winner among current requesters; data is the idle default
    always_comb begin
        win = OwnerData;
        if (inst_sram_req && data_sram_req) begin
`ifdef ARB_RR_EN
            win = rr_q;
`else
            win = OwnerData;
`endif
        end else if (inst_sram_req) begin
            win = OwnerInst;
        end
    end

    // A pop frees a slot this cycle, so a full FIFO may still accept
    assign pop       = bus_data_ok & ~fifo_empty;
    assign can_issue = ~fifo_full | pop;

    // Request and grant: frozen in HOLD, combinational in IDLE
    always_comb begin
        if (state_q == StHold) begin
            grant   = grant_q;
            bus_req = 1'b1;
        end else begin
            grant   = win;
            bus_req = (inst_sram_req | data_sram_req) & can_issue;
        end
    end

    assign accept = bus_req & bus_addr_ok;

    // Bus field mux follows the grant
    always_comb begin
        if (grant == OwnerInst) begin
            bus_wr    = inst_sram_wr;
            bus_size  = inst_sram_size;
            bus_wstrb = inst_sram_wstrb;
            bus_addr  = inst_sram_addr;
            bus_wdata = inst_sram_wdata;
        end else begin
            bus_wr    = data_sram_wr;
            bus_size  = data_sram_size;
            bus_wstrb = data_sram_wstrb;
            bus_addr  = data_sram_addr;
            bus_wdata = data_sram_wdata;
        end
    end

    assign inst_sram_addr_ok = accept & (grant == OwnerInst);
    assign data_sram_addr_ok = accept & (grant == OwnerData);

    // Responses go to the FIFO head owner with zero latency
    always_comb begin
        inst_sram_data_ok = pop & (head == OwnerInst);
        data_sram_data_ok = pop & (head == OwnerData);
        inst_sram_rdata   = inst_sram_data_ok ? bus_rdata : 32'h0;
        data_sram_rdata   = data_sram_data_ok ? bus_rdata : 32'h0;
    end

    // Lock FSM next-state: hold the grant while an exposed request is unaccepted
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        arb_err_d = arb_err_q | (bus_data_ok & fifo_empty);
        case (state_q)
            StIdle: begin
                if (bus_req && !bus_addr_ok) begin
                    state_d = StHold;
                    grant_d = win;
                end
            end
            StHold: begin
                if (bus_addr_ok) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM, frozen grant and sticky error registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            grant_q   <= OwnerData;
            arb_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            arb_err_q <= arb_err_d;
        end
    end

    assign arb_err = arb_err_q;

    sram_port_arbiter_owner_fifo #(
        .Depth (OUTS_DEPTH)
    ) u_owner_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_owner (grant),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (head)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter (OUTS_DEPTH = 4).
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        arb_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .OUTS_DEPTH (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .bus_req           (bus_req),
        .bus_wr            (bus_wr),
        .bus_size          (bus_size),
        .bus_wstrb         (bus_wstrb),
        .bus_addr          (bus_addr),
        .bus_wdata         (bus_wdata),
        .bus_addr_ok       (bus_addr_ok),
        .bus_data_ok       (bus_data_ok),
        .bus_rdata         (bus_rdata),
        .arb_err           (arb_err)
    );

    // Drive everything idle, hold reset across one posedge
    task automatic do_reset();
        @(negedge clk);
        reset           = 1'b1;
        inst_sram_req   = 1'b0;
        inst_sram_wr    = 1'b0;
        inst_sram_size  = 2'd2;
        inst_sram_wstrb = 4'hf;
        inst_sram_addr  = 32'h0;
        inst_sram_wdata = 32'h0;
        data_sram_req   = 1'b0;
        data_sram_wr    = 1'b0;
        data_sram_size  = 2'd2;
        data_sram_wstrb = 4'hf;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        bus_addr_ok     = 1'b0;
        bus_data_ok     = 1'b0;
        bus_rdata       = 32'h0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (bus_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_bus_req: got %b want 0", bus_req);
        end
        n_checks++;
        if ({inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok} !== 4'b0)
        begin
            n_fail++;
            $display("FAIL reset_oks: got %b%b%b%b want 0000", inst_sram_addr_ok,
                     data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok);
        end
        n_checks++;
        if (arb_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_arb_err: got %b want 0", arb_err);
        end
    endtask

    task automatic test_lone_inst();
        do_reset();
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0000;
        bus_addr_ok    = 1'b1;
        #1;
        n_checks++;
        if (inst_sram_addr_ok !== 1'b1 || bus_req !== 1'b1) begin
            n_fail++;
            $display("FAIL lone_addr_ok: got addr_ok=%b bus_req=%b want 1 1",
                     inst_sram_addr_ok, bus_req);
        end
        n_checks++;
        if (bus_addr !== 32'h1c00_0000) begin
            n_fail++; $display("FAIL lone_bus_addr: got %h want 1c000000", bus_addr);
        end
        @(negedge clk);
        inst_sram_req = 1'b0;
        bus_addr_ok   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (inst_sram_data_ok !== 1'b0) begin
                n_fail++; $display("FAIL lone_early_data_ok: got %b want 0", inst_sram_data_ok);
            end
            @(negedge clk);
        end
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h0280_0000;
        #1;
        n_checks++;
        if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h0280_0000) begin
            n_fail++;
            $display("FAIL lone_data: got ok=%b rdata=%h want 1 02800000",
                     inst_sram_data_ok, inst_sram_rdata);
        end
        n_checks++;
        if (data_sram_data_ok !== 1'b0) begin
            n_fail++; $display("FAIL lone_data_side: got %b want 0", data_sram_data_ok);
        end
        @(negedge clk);
        bus_data_ok = 1'b0;
    endtask

    task automatic test_conflict();
        do_reset();
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0040;
        data_sram_req  = 1'b1;
        data_sram_addr = 32'h0000_2000;
        bus_addr_ok    = 1'b1;
        #1;
        n_checks++;
        if (data_sram_addr_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0 ||
            bus_addr !== 32'h0000_2000) begin
            n_fail++;
            $display("FAIL conflict_first: got d=%b i=%b addr=%h want 1 0 00002000",
                     data_sram_addr_ok, inst_sram_addr_ok, bus_addr);
        end
        @(negedge clk);
        data_sram_req = 1'b0;
        #1;
        n_checks++;
        if (inst_sram_addr_ok !== 1'b1 || bus_addr !== 32'h1c00_0040) begin
            n_fail++;
            $display("FAIL conflict_second: got i=%b addr=%h want 1 1c000040",
                     inst_sram_addr_ok, bus_addr);
        end
        @(negedge clk);
        inst_sram_req = 1'b0;
        bus_addr_ok   = 1'b0;
        bus_data_ok   = 1'b1;
        bus_rdata     = 32'haaaa_0001;
        #1;
        n_checks++;
        if (data_sram_data_ok !== 1'b1 || inst_sram_data_ok !== 1'b0 ||
            data_sram_rdata !== 32'haaaa_0001) begin
            n_fail++;
            $display("FAIL conflict_resp1: got d=%b i=%b rdata=%h want 1 0 aaaa0001",
                     data_sram_data_ok, inst_sram_data_ok, data_sram_rdata);
        end
        @(negedge clk);
        bus_rdata = 32'hbbbb_0002;
        #1;
        n_checks++;
        if (inst_sram_data_ok !== 1'b1 || data_sram_data_ok !== 1'b0 ||
            inst_sram_rdata !== 32'hbbbb_0002) begin
            n_fail++;
            $display("FAIL conflict_resp2: got i=%b d=%b rdata=%h want 1 0 bbbb0002",
                     inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata);
        end
        @(negedge clk);
        bus_data_ok = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        data_sram_req  = 1'b1;
        data_sram_addr = 32'h0000_1000;
        inst_sram_addr = 32'h1c00_0080;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) inst_sram_req = 1'b1;
            #1;
            n_checks++;
            if (bus_req !== 1'b1 || bus_addr !== 32'h0000_1000 || inst_sram_addr_ok !== 1'b0)
            begin
                n_fail++;
                $display("FAIL lock_cycle%0d: got req=%b addr=%h i_ok=%b want 1 00001000 0",
                         i, bus_req, bus_addr, inst_sram_addr_ok);
            end
            @(negedge clk);
        end
        bus_addr_ok = 1'b1;
        #1;
        n_checks++;
        if (data_sram_addr_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0 ||
            bus_addr !== 32'h0000_1000) begin
            n_fail++;
            $display("FAIL lock_release: got d=%b i=%b addr=%h want 1 0 00001000",
                     data_sram_addr_ok, inst_sram_addr_ok, bus_addr);
        end
        @(negedge clk);
        data_sram_req = 1'b0;
        #1;
        n_checks++;
        if (inst_sram_addr_ok !== 1'b1 || bus_addr !== 32'h1c00_0080) begin
            n_fail++;
            $display("FAIL lock_next: got i=%b addr=%h want 1 1c000080",
                     inst_sram_addr_ok, bus_addr);
        end
        @(negedge clk);
        inst_sram_req = 1'b0;
        bus_addr_ok   = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0100;
        bus_addr_ok    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (inst_sram_addr_ok !== 1'b1) begin
                n_fail++; $display("FAIL full_fill%0d: got %b want 1", i, inst_sram_addr_ok);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (bus_req !== 1'b0 || inst_sram_addr_ok !== 1'b0) begin
                n_fail++;
                $display("FAIL full_block%0d: got req=%b ok=%b want 0 0",
                         i, bus_req, inst_sram_addr_ok);
            end
            @(negedge clk);
        end
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hcafe_0000;
        #1;
        n_checks++;
        if (bus_req !== 1'b1 || inst_sram_addr_ok !== 1'b1 || inst_sram_data_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL full_push_pop: got req=%b aok=%b dok=%b want 1 1 1",
                     bus_req, inst_sram_addr_ok, inst_sram_data_ok);
        end
        @(negedge clk);
        bus_data_ok = 1'b0;
        #1;
        n_checks++;
        if (bus_req !== 1'b0) begin
            n_fail++; $display("FAIL full_still_full: got req=%b want 0", bus_req);
        end
        @(negedge clk);
        inst_sram_req = 1'b0;
        bus_addr_ok   = 1'b0;
    endtask

    task automatic test_spurious();
        do_reset();
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hdead_beef;
        #1;
        n_checks++;
        if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0 || arb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_cycle: got i=%b d=%b err=%b want 0 0 0",
                     inst_sram_data_ok, data_sram_data_ok, arb_err);
        end
        @(negedge clk);
        bus_data_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (arb_err !== 1'b1) begin
                n_fail++; $display("FAIL spur_sticky%0d: got %b want 1", i, arb_err);
            end
            @(negedge clk);
        end
        do_reset();
        #1;
        n_checks++;
        if (arb_err !== 1'b0) begin
            n_fail++; $display("FAIL spur_cleared: got %b want 0", arb_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_data;
`ifdef ARB_RR_EN
        exp_data = 4'b0101;  // bit i = data wins in cycle i: D,I,D,I
`else
        exp_data = 4'b1111;
`endif
        do_reset();
        inst_sram_req  = 1'b1;
        data_sram_req  = 1'b1;
        inst_sram_addr = 32'h1c00_0200;
        data_sram_addr = 32'h0000_3000;
        bus_addr_ok    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (data_sram_addr_ok !== exp_data[i] || inst_sram_addr_ok !== !exp_data[i]) begin
                n_fail++;
                $display("FAIL b2b_owner%0d: got d=%b i=%b want d=%b i=%b", i,
                         data_sram_addr_ok, inst_sram_addr_ok, exp_data[i], !exp_data[i]);
            end
            @(negedge clk);
        end
        inst_sram_req = 1'b0;
        data_sram_req = 1'b0;
        bus_addr_ok   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lone_inst();
        test_conflict();
        test_lock();
        test_full();
        test_spurious();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
